// File: rtl/ps2_kbd_rx_fifo.sv
// rtl/ps2_kbd_rx_fifo.sv - PS/2 keyboard receiver with frame checks, E0/F0 decode and FWFT event FIFO
// Define PS2_ASCII_EN to build the US-layout ASCII table and shift tracking.
module ps2_kbd_rx_fifo #(
  parameter int FIFO_AW     = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_code,
  output logic             out_break,
  output logic             out_ext,
  output logic [7:0]       out_ascii,
  output logic [FIFO_AW:0] fifo_count,
  output logic             overflow,
  output logic             frame_err
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  // Lines idle high, so the synchronisers reset high to avoid a false fall.
  logic [2:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       fall;
  logic       bit_in;

  assign fall   = (clk_sync_q[2:1] == 2'b10);
  assign bit_in = dat_sync_q[1];

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_d, good_d, timeout;
  logic          frame_err_q;
  logic          rx_vld_q;
  logic [7:0]    rx_byte_q;

  assign timeout = (state_q != S_IDLE) && !fall && (to_cnt_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    err_d     = 1'b0;
    good_d    = 1'b0;
    to_cnt_d  = (state_q == S_IDLE || fall) ? '0 : to_cnt_q + TW'(1);
    if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!bit_in) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
        S_DATA: begin
          shreg_d   = {bit_in, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = bit_in;
          state_d = S_STOP;
        end
        default: begin
          if (bit_in && (^{shreg_q, par_q})) good_d = 1'b1;
          else                               err_d  = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end else if (timeout) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 3'b111;
      dat_sync_q  <= 2'b11;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'h00;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      frame_err_q <= 1'b0;
      rx_vld_q    <= 1'b0;
      rx_byte_q   <= 8'h00;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q  <= {dat_sync_q[0], ps2_data};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= err_d;
      rx_vld_q    <= good_d;
      if (good_d) rx_byte_q <= shreg_q;
    end
  end

  assign frame_err = frame_err_q;

  logic       ext_q, ext_d, brk_q, brk_d, push;
  logic [7:0] push_ascii;

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    push  = 1'b0;
    if (rx_vld_q) begin
      if (rx_byte_q == 8'hE0)      ext_d = 1'b1;
      else if (rx_byte_q == 8'hF0) brk_d = 1'b1;
      else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
    end
  end

`ifdef PS2_ASCII_EN
  logic lshift_q, lshift_d, rshift_q, rshift_d;

  // Each entry is {unshifted, shifted}.
  function automatic logic [7:0] ascii_lut(input logic shift, input logic [7:0] code);
    logic [15:0] pair;
    case (code)
      8'h1C: pair = 16'h6141;  8'h32: pair = 16'h6242;  8'h21: pair = 16'h6343;
      8'h23: pair = 16'h6444;  8'h24: pair = 16'h6545;  8'h2B: pair = 16'h6646;
      8'h34: pair = 16'h6747;  8'h33: pair = 16'h6848;  8'h43: pair = 16'h6949;
      8'h3B: pair = 16'h6A4A;  8'h42: pair = 16'h6B4B;  8'h4B: pair = 16'h6C4C;
      8'h3A: pair = 16'h6D4D;  8'h31: pair = 16'h6E4E;  8'h44: pair = 16'h6F4F;
      8'h4D: pair = 16'h7050;  8'h15: pair = 16'h7151;  8'h2D: pair = 16'h7252;
      8'h1B: pair = 16'h7353;  8'h2C: pair = 16'h7454;  8'h3C: pair = 16'h7555;
      8'h2A: pair = 16'h7656;  8'h1D: pair = 16'h7757;  8'h22: pair = 16'h7858;
      8'h35: pair = 16'h7959;  8'h1A: pair = 16'h7A5A;
      8'h45: pair = 16'h3029;  8'h16: pair = 16'h3121;  8'h1E: pair = 16'h3240;
      8'h26: pair = 16'h3323;  8'h25: pair = 16'h3424;  8'h2E: pair = 16'h3525;
      8'h36: pair = 16'h365E;  8'h3D: pair = 16'h3726;  8'h3E: pair = 16'h382A;
      8'h46: pair = 16'h3928;
      8'h0E: pair = 16'h607E;  8'h4E: pair = 16'h2D5F;  8'h55: pair = 16'h3D2B;
      8'h54: pair = 16'h5B7B;  8'h5B: pair = 16'h5D7D;  8'h5D: pair = 16'h5C7C;
      8'h4C: pair = 16'h3B3A;  8'h52: pair = 16'h2722;  8'h41: pair = 16'h2C3C;
      8'h49: pair = 16'h2E3E;  8'h4A: pair = 16'h2F3F;  8'h29: pair = 16'h2020;
      default: pair = 16'h0000;
    endcase
    return shift ? pair[7:0] : pair[15:8];
  endfunction

  always_comb begin
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    if (push && !ext_q) begin
      if (rx_byte_q == 8'h12) lshift_d = !brk_q;
      if (rx_byte_q == 8'h59) rshift_d = !brk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
    end else begin
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
    end
  end

  assign push_ascii = ext_q ? 8'h00 : ascii_lut(lshift_q | rshift_q, rx_byte_q);
`else
  assign push_ascii = 8'h00;
`endif

  logic [17:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, full, pop, do_push;
  logic [17:0]        head;

  assign full    = (count_q == (FIFO_AW + 1)'(DEPTH));
  assign pop     = (count_q != '0) && out_ready;
  assign do_push = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !pop)      count_d = count_q + (FIFO_AW + 1)'(1);
    else if (!do_push && pop) count_d = count_q - (FIFO_AW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {ext_q, brk_q, rx_byte_q, push_ascii};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      count_q <= count_d;
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  // Head is masked while empty so unwritten storage never reaches the outputs.
  assign head       = mem_q[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign out_ext    = out_valid ? head[17]    : 1'b0;
  assign out_break  = out_valid ? head[16]    : 1'b0;
  assign out_code   = out_valid ? head[15:8]  : 8'h00;
  assign out_ascii  = out_valid ? head[7:0]   : 8'h00;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// tb/tb_ps2_kbd_rx_fifo.sv - randomized self-checking bench for ps2_kbd_rx_fifo
module tb_ps2_kbd_rx_fifo;
  localparam int AW = 3;
  localparam int TO = 300;
  localparam int HP = 15;

  logic          clk = 1'b0;
  logic          rst, ps2_clk, ps2_data, out_ready;
  logic          out_valid, out_break, out_ext, overflow, frame_err;
  logic [7:0]    out_code, out_ascii;
  logic [AW:0]   fifo_count;

  always #5 clk = ~clk;

  ps2_kbd_rx_fifo #(.FIFO_AW(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_break(out_break), .out_ext(out_ext), .out_ascii(out_ascii),
    .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err)
  );

  typedef struct packed {logic ext; logic brk; logic [7:0] code; logic [7:0] ascii;} ev_t;

  int   n_vec = 0, n_bad = 0;
  ev_t  got_q[$], exp_q[$];
  int   err_seen, valid_cycles, m_err;
  logic smp_v3, smp_v4, smp_fe3;
  logic [AW:0] smp_cnt;
  logic m_ext, m_brk, m_lsh, m_rsh;
  logic hold_v = 1'b0;
  ev_t  hold_ev;
  bit   rnd_done;
  logic [7:0] lo_tab [256];
  logic [7:0] hi_tab [256];
  logic [7:0] lcodes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                              8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] dcodes [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0] pcodes [12] = '{8'h0E,8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,8'h49,8'h4A,8'h29};
  logic [7:0] pun_lo [12] = '{8'h60,8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,8'h2C,8'h2E,8'h2F,8'h20};
  logic [7:0] pun_hi [12] = '{8'h7E,8'h5F,8'h2B,8'h7B,8'h7D,8'h7C,8'h3A,8'h22,8'h3C,8'h3E,8'h3F,8'h20};

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (out_valid) valid_cycles++;
      if (frame_err) err_seen++;
      if (hold_v) begin
        n_vec++;
        if ({out_valid, out_ext, out_break, out_code, out_ascii} !== {1'b1, hold_ev}) begin
          n_bad++;
          $display("FAIL hold_stable: got %h expected %h", {out_valid, out_ext, out_break, out_code, out_ascii}, {1'b1, hold_ev});
        end
      end
      if (out_valid && out_ready) got_q.push_back({out_ext, out_break, out_code, out_ascii});
      hold_v  = out_valid && !out_ready;
      hold_ev = {out_ext, out_break, out_code, out_ascii};
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic init_tables();
    string letters_lo = "abcdefghijklmnopqrstuvwxyz";
    string letters_hi = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    string dig_lo = "0123456789";
    string dig_hi = ")!@#$%^&*(";
    for (int i = 0; i < 256; i++) begin lo_tab[i] = 8'h00; hi_tab[i] = 8'h00; end
    for (int i = 0; i < 26; i++) begin lo_tab[lcodes[i]] = letters_lo[i]; hi_tab[lcodes[i]] = letters_hi[i]; end
    for (int i = 0; i < 10; i++) begin lo_tab[dcodes[i]] = dig_lo[i]; hi_tab[dcodes[i]] = dig_hi[i]; end
    for (int i = 0; i < 12; i++) begin lo_tab[pcodes[i]] = pun_lo[i]; hi_tab[pcodes[i]] = pun_hi[i]; end
  endtask

  // Reference decoder: prefixes set flags, any other byte is an event.
  task automatic model_byte(input logic [7:0] b, input bit bad);
    logic [7:0] a;
    if (bad) begin m_err++; return; end
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      a = m_ext ? 8'h00 : ((m_lsh || m_rsh) ? hi_tab[b] : lo_tab[b]);
`ifndef PS2_ASCII_EN
      a = 8'h00;
`endif
      exp_q.push_back({m_ext, m_brk, b, a});
      if (!m_ext && b == 8'h12) m_lsh = !m_brk;
      if (!m_ext && b == 8'h59) m_rsh = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; out_ready = 1'b0;
    wait_cyc(3);
    got_q.delete(); exp_q.delete();
    err_seen = 0; valid_cycles = 0; m_err = 0;
    m_ext = 1'b0; m_brk = 1'b0; m_lsh = 1'b0; m_rsh = 1'b0;
    rst = 1'b0;
    wait_cyc(1);
  endtask

  // mode 1: one-cycle out_ready aligned to the push; mode 2: sample latency around the stop bit
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int mode);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = f[i];
      wait_cyc(HP / 2);
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        wait_cyc(3); out_ready = 1'b1;
        wait_cyc(1); out_ready = 1'b0; smp_cnt = fifo_count;
        wait_cyc(HP - 4);
      end else if (i == 10 && mode == 2) begin
        wait_cyc(3); smp_v3 = out_valid; smp_fe3 = frame_err;
        wait_cyc(1); smp_v4 = out_valid;
        wait_cyc(HP - 4);
      end else begin
        wait_cyc(HP);
      end
      ps2_clk = 1'b1;
      wait_cyc(HP - HP / 2);
    end
    ps2_data = 1'b1;
    wait_cyc(10);
    model_byte(b, bad_par || bad_stop);
  endtask

  task automatic test_reset();
    logic [10:0] f;
    do_reset();
    f = {1'b1, 1'b0, 8'h5A, 1'b0};
    for (int i = 0; i < 4; i++) begin
      ps2_data = f[i]; wait_cyc(HP / 2); ps2_clk = 1'b0; wait_cyc(HP); ps2_clk = 1'b1; wait_cyc(HP - HP / 2);
    end
    do_reset();
    n_vec++; if (out_valid !== 1'b0)   begin n_bad++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    n_vec++; if (fifo_count !== '0)    begin n_bad++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
    n_vec++; if (overflow !== 1'b0)    begin n_bad++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    n_vec++; if (frame_err !== 1'b0)   begin n_bad++; $display("FAIL rst_frame_err: got %b expected 0", frame_err); end
    n_vec++; if (out_code !== 8'h00)   begin n_bad++; $display("FAIL rst_code: got %h expected 00", out_code); end
    n_vec++; if (out_break !== 1'b0)   begin n_bad++; $display("FAIL rst_break: got %b expected 0", out_break); end
    n_vec++; if (out_ext !== 1'b0)     begin n_bad++; $display("FAIL rst_ext: got %b expected 0", out_ext); end
    n_vec++; if (out_ascii !== 8'h00)  begin n_bad++; $display("FAIL rst_ascii: got %h expected 00", out_ascii); end
    out_ready = 1'b1;
    send_frame(8'h33, 1'b0, 1'b0, 0);
    n_vec++; if (err_seen !== 0) begin n_bad++; $display("FAIL rst_midframe_err: got %0d expected 0", err_seen); end
    n_vec++;
    if (got_q.size() !== 1 || got_q[0].code !== 8'h33) begin
      n_bad++; $display("FAIL rst_midframe_event: got %0d events expected 1 with code 33", got_q.size());
    end
  endtask

  task automatic test_single();
    ev_t e;
`ifdef PS2_ASCII_EN
    e = {1'b0, 1'b0, 8'h1C, 8'h61};
`else
    e = {1'b0, 1'b0, 8'h1C, 8'h00};
`endif
    do_reset();
    out_ready = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b0, 2);
    n_vec++; if (smp_v3 !== 1'b0)   begin n_bad++; $display("FAIL single_valid_n1: got %b expected 0", smp_v3); end
    n_vec++; if (smp_v4 !== 1'b1)   begin n_bad++; $display("FAIL single_valid_n2: got %b expected 1", smp_v4); end
    n_vec++; if (smp_fe3 !== 1'b0)  begin n_bad++; $display("FAIL single_frame_err: got %b expected 0", smp_fe3); end
    n_vec++; if (valid_cycles !== 1) begin n_bad++; $display("FAIL single_valid_cycles: got %0d expected 1", valid_cycles); end
    n_vec++;
    if (got_q.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
    else if (got_q[0] !== e) begin n_bad++; $display("FAIL single_event: got %h expected %h", got_q[0], e); end
  endtask

  task automatic test_shift();
    logic [7:0] seq [7] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    ev_t want [5];
    logic [7:0] up, lo;
`ifdef PS2_ASCII_EN
    up = 8'h41; lo = 8'h61;
`else
    up = 8'h00; lo = 8'h00;
`endif
    want = '{{2'b00, 8'h12, 8'h00}, {2'b00, 8'h1C, up}, {2'b01, 8'h1C, up}, {2'b01, 8'h12, 8'h00}, {2'b00, 8'h1C, lo}};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_frame(seq[i], 1'b0, 1'b0, 0);
    n_vec++; if (got_q.size() !== 5) begin n_bad++; $display("FAIL shift_len: got %0d expected 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== want[i]) begin n_bad++; $display("FAIL shift_ev%0d: got %h expected %h", i, got_q[i], want[i]); end
    end
  endtask

  task automatic test_ext();
    logic [7:0] seq [5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    ev_t want [2];
    want = '{{2'b10, 8'h75, 8'h00}, {2'b11, 8'h75, 8'h00}};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_frame(seq[i], 1'b0, 1'b0, 0);
    n_vec++; if (got_q.size() !== 2) begin n_bad++; $display("FAIL ext_len: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== want[i]) begin n_bad++; $display("FAIL ext_ev%0d: got %h expected %h", i, got_q[i], want[i]); end
    end
  endtask

  task automatic test_bad_frames();
    do_reset();
    out_ready = 1'b1;
    send_frame(8'h1C, 1'b1, 1'b0, 2);
    n_vec++; if (smp_fe3 !== 1'b1) begin n_bad++; $display("FAIL parity_err_pulse: got %b expected 1", smp_fe3); end
    n_vec++; if (err_seen !== 1)   begin n_bad++; $display("FAIL parity_err_cycles: got %0d expected 1", err_seen); end
    send_frame(8'h2B, 1'b0, 1'b1, 2);
    n_vec++; if (smp_fe3 !== 1'b1) begin n_bad++; $display("FAIL stop_err_pulse: got %b expected 1", smp_fe3); end
    n_vec++; if (err_seen !== 2)   begin n_bad++; $display("FAIL stop_err_cycles: got %0d expected 2", err_seen); end
    n_vec++; if (fifo_count !== '0) begin n_bad++; $display("FAIL bad_count: got %0d expected 0", fifo_count); end
    n_vec++; if (valid_cycles !== 0) begin n_bad++; $display("FAIL bad_pushed: got %0d valid cycles expected 0", valid_cycles); end
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    logic [10:0] f;
    do_reset();
    out_ready = 1'b1;
    b = 8'($urandom_range(0, 255));
    f = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < 6; i++) begin
      ps2_data = f[i]; wait_cyc(HP / 2); ps2_clk = 1'b0; wait_cyc(HP); ps2_clk = 1'b1; wait_cyc(HP - HP / 2);
    end
    ps2_data = 1'b1;
    m_err++;
    wait_cyc(TO + 20);
    n_vec++; if (err_seen !== 1) begin n_bad++; $display("FAIL timeout_err: got %0d expected 1", err_seen); end
    send_frame(8'h29, 1'b0, 1'b0, 0);
    n_vec++; if (err_seen !== m_err) begin n_bad++; $display("FAIL timeout_after_err: got %0d expected %0d", err_seen, m_err); end
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL timeout_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL timeout_ev%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_vec++;
    if (got_q.size() < 1 || got_q[0].code !== 8'h29) begin n_bad++; $display("FAIL timeout_code: got %0d events expected code 29", got_q.size()); end
  endtask

  task automatic test_random();
    do_reset();
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          int r;
          logic [7:0] b;
          r = $urandom_range(0, 9);
          case (r)
            0: b = 8'hE0;
            1: b = 8'hF0;
            2: b = 8'h12;
            3: b = 8'h59;
            4, 5: b = lcodes[$urandom_range(0, 25)];
            6: b = pcodes[$urandom_range(0, 11)];
            default: b = 8'($urandom_range(0, 255));
          endcase
          send_frame(b, ($urandom_range(0, 9) == 0), 1'b0, 0);
        end
        wait_cyc(20);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = 1'($urandom_range(0, 1));
          wait_cyc(1);
        end
        out_ready = 1'b1;
      end
    join
    wait_cyc(5);
    n_vec++; if (err_seen !== m_err) begin n_bad++; $display("FAIL rand_err: got %0d expected %0d", err_seen, m_err); end
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_ev%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rand_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [10];
    for (int i = 0; i < 10; i++) begin
      do codes[i] = 8'($urandom_range(1, 8'h83)); while (codes[i] == 8'h12 || codes[i] == 8'h59);
    end
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_frame(codes[i], 1'b0, 1'b0, 0);
    exp_q.delete(8);
    n_vec++; if (fifo_count !== 4'd8) begin n_bad++; $display("FAIL ovf_count: got %0d expected 8", fifo_count); end
    n_vec++; if (overflow !== 1'b1)   begin n_bad++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    n_vec++; if (out_code !== codes[0]) begin n_bad++; $display("FAIL ovf_head: got %h expected %h", out_code, codes[0]); end
    send_frame(codes[9], 1'b0, 1'b0, 1);
    n_vec++; if (smp_cnt !== 4'd8) begin n_bad++; $display("FAIL ovf_push_pop_count: got %0d expected 8", smp_cnt); end
    out_ready = 1'b1;
    wait_cyc(20);
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL ovf_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL ovf_ev%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (fifo_count !== '0) begin n_bad++; $display("FAIL ovf_drained: got %0d expected 0", fifo_count); end
    n_vec++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    do_reset();
    n_vec++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_reset: got %b expected 0", overflow); end
  endtask

  initial begin
    init_tables();
    test_reset();
    test_single();
    test_shift();
    test_ext();
    test_bad_frames();
    test_timeout();
    test_random();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
